// File: rtl/muldiv_unit_pkg.sv
// Shared kanade32 HI/LO unit definitions: op codes, FSM states, datapath width.
package muldiv_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] value, input logic is_signed);
    if (is_signed && value[XLEN-1]) begin
      magnitude = ~value + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      magnitude = value;
    end
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the shared datapath: shift-add multiply or restoring-divide step
// on the {upper, lower} accumulator.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   div_top;
  logic [XLEN-1:0] rem_sub;
  logic            fits;

  // Single combinational step; the divide trial keeps an extra top bit so 2*rem+1 never overflows.
  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    div_top  = acc[2*XLEN-1:XLEN-1];
    fits     = (div_top >= {1'b0, operand});
    rem_sub  = div_top[XLEN-1:0] - operand;
    if (is_div) begin
      if (fits) begin
        acc_next = {rem_sub, acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {add_sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: operates on magnitudes for XLEN iterations,
// then applies sign correction and writes {hi,lo} in a final FIX cycle.
module muldiv_unit #(
  parameter int XLEN  = muldiv_unit_pkg::XLEN,
  parameter int CNT_W = muldiv_unit_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mthi_wren,
  input  logic            mtlo_wren,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  import muldiv_unit_pkg::*;

  md_state_t         state;
  md_state_t         next_state;
  logic              load;
  logic              step;
  logic              fix;
  logic              mt_hi;
  logic              mt_lo;
  logic              op_signed;
  logic              op_div;
  logic              is_div;
  logic              neg_quot;
  logic              neg_rem;
  logic              div_zero;
  logic [XLEN-1:0]   rs_hold;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;
  logic [2*XLEN-1:0] prod_neg;

  muldiv_core #(.XLEN(XLEN)) u_core (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != MD_IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      MD_IDLE: next_state = start ? MD_RUN : MD_IDLE;
      MD_RUN:  next_state = (cnt == CNT_W'(XLEN-1)) ? MD_FIX : MD_RUN;
      MD_FIX:  next_state = MD_IDLE;
      default: next_state = MD_IDLE;
    endcase
  end

  // Control decode; start beats an MT write in the same IDLE cycle.
  always_comb begin
    load  = 1'b0;
    step  = 1'b0;
    fix   = 1'b0;
    mt_hi = 1'b0;
    mt_lo = 1'b0;
    case (state)
      MD_IDLE: begin
        load  = start;
        mt_hi = !start && mthi_wren;
        mt_lo = !start && mtlo_wren;
      end
      MD_RUN:  step = 1'b1;
      MD_FIX:  fix  = 1'b1;
      default: load = 1'b0;
    endcase
  end

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign op_div    = (op == MD_DIV) || (op == MD_DIVU);

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div   <= 1'b0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      rs_hold  <= {XLEN{1'b0}};
      operand  <= {XLEN{1'b0}};
      acc      <= {(2*XLEN){1'b0}};
      cnt      <= {CNT_W{1'b0}};
    end else if (load) begin
      is_div   <= op_div;
      neg_quot <= op_signed && (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
      neg_rem  <= op_signed && rs_data[XLEN-1];
      div_zero <= (rt_data == {XLEN{1'b0}});
      rs_hold  <= rs_data;
      operand  <= op_div ? magnitude(rt_data, op_signed) : magnitude(rs_data, op_signed);
      acc      <= {{XLEN{1'b0}}, (op_div ? magnitude(rs_data, op_signed) : magnitude(rt_data, op_signed))};
      cnt      <= {CNT_W{1'b0}};
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (fix) begin
      cnt <= {CNT_W{1'b0}};
    end else begin
      cnt <= cnt;
    end
  end

  // Sign correction; a zero divisor bypasses it and returns the raw dividend in hi.
  always_comb begin
    prod_neg = ~acc + {{(2*XLEN-1){1'b0}}, 1'b1};
    fix_hi   = acc[2*XLEN-1:XLEN];
    fix_lo   = acc[XLEN-1:0];
    if (!is_div) begin
      if (neg_quot) begin
        fix_hi = prod_neg[2*XLEN-1:XLEN];
        fix_lo = prod_neg[XLEN-1:0];
      end else begin
        fix_hi = acc[2*XLEN-1:XLEN];
        fix_lo = acc[XLEN-1:0];
      end
    end else if (div_zero) begin
      fix_hi = rs_hold;
      fix_lo = {XLEN{1'b1}};
    end else begin
      fix_lo = neg_quot ? (~acc[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1}) : acc[XLEN-1:0];
      fix_hi = neg_rem ? (~acc[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1}) : acc[2*XLEN-1:XLEN];
    end
  end

  // HI/LO architectural registers and completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= {XLEN{1'b0}};
      lo   <= {XLEN{1'b0}};
      done <= 1'b0;
    end else begin
      done <= fix;
      if (fix) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else begin
        if (mt_hi) begin
          hi <= rs_data;
        end else begin
          hi <= hi;
        end
        if (mt_lo) begin
          lo <= rs_data;
        end else begin
          lo <= lo;
        end
      end
    end
  end

endmodule
